kinase_valve_sequencer: RTL and testbench
=========================================

KINASE_VALVE_SEQUENCER -- requirements
Module: kinase_valve_sequencer

Interface
REQ-001 SHALL have parameter PHASE_TICKS, default 1000, clocks per pump phase (legal range 1..65535).
REQ-002 SHALL have parameter SETTLE_TICKS, default 5000, clocks of valve settling before pumping (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when valid&ready.
REQ-007 SHALL have port cmd_valves  input  13  pattern for c1..c13 (bit0=c1).
REQ-008 SHALL have port cmd_sieve  input  4  pattern for s1..s4 (bit0=s1).
REQ-009 SHALL have port cmd_pump_cycles  input  8  peristaltic cycles to run (0 = none).
REQ-010 SHALL have port abort  input  1  synchronous abort request.
REQ-011 SHALL have port c  output  13  control valve drive to device c1..c13.
REQ-012 SHALL have port s  output  4  sieve valve drive to s1..s4.
REQ-013 SHALL have port p  output  5  pump/isolation drive to p1..p5 (bit0=p1).
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL encode valves as 1 = closed (pressurized), 0 = open; all outputs registered.
REQ-017 SHALL implement FSM IDLE, SETTLE, PUMP, DONE; cmd_ready = 1 only in IDLE.
REQ-018 SHALL, on accept in cycle T, present c=cmd_valves, s=cmd_sieve from T+1 and enter SETTLE; pump_cycles latched.
REQ-019 SHALL stay in SETTLE exactly SETTLE_TICKS cycles, p held 5'b11111.
REQ-020 SHALL leave SETTLE for PUMP if latched cycles > 0, else for DONE.
REQ-021 SHALL in PUMP drive p[4:3]=2'b00 (isolation open) and p[2:0] through phases 0..5 = 110,100,101,001,011,010, each PHASE_TICKS cycles.
REQ-022 SHALL run exactly cmd_pump_cycles full 6-phase cycles, then enter DONE; 255 cycles with no counter overflow.
REQ-023 SHALL in DONE assert done for one cycle, set p=5'b11111, then return to IDLE; c/s hold last command values.
REQ-024 SHALL give total busy duration SETTLE_TICKS + 6*PHASE_TICKS*N + 1 cycles for N pump cycles.
REQ-025 SHALL on abort in SETTLE/PUMP/DONE go to IDLE next cycle with c, s, p all ones and done not asserted.
REQ-026 SHALL ignore abort in IDLE; abort has priority over a same-cycle command accept (command dropped).
REQ-027 SHALL ignore cmd_* inputs while busy; no queuing.

Reset
REQ-028 SHALL on rst force IDLE, c=13'h1FFF, s=4'hF, p=5'h1F, busy=0, done=0, counters=0, cmd_ready=1 after release.
REQ-029 SHALL on rst mid-operation discard latched command entirely; same values as REQ-028.

Configuration
REQ-030 SHALL, with macro KINASE_PUMP_REVERSE_EN defined, add input cmd_reverse (1 bit) latched at accept; when 1, phases run 5..0 each cycle.
REQ-031 SHALL, without KINASE_PUMP_REVERSE_EN, have no cmd_reverse port and pump forward only.

Verification (PHASE_TICKS=2, SETTLE_TICKS=3)
REQ-032 SHALL cover: reset asserted mid-PUMP -> c=1FFF, s=F, p=1F, busy=0 immediately (asynchronous).
REQ-033 SHALL cover: cmd valves=0x0A5, sieve=0x3, cycles=1 -> c=0x0A5 from T+1, p[2:0] sequence 110,100,101,001,011,010 two clocks each, done at T+16, busy 16 cycles.
REQ-034 SHALL cover: cycles=0 -> no p change, done at T+4, busy 4 cycles.
REQ-035 SHALL cover: abort during phase 3 of cycle 2 of a 3-cycle command -> next cycle all outputs ones, no done, cmd_ready=1.
REQ-036 SHALL cover: cmd_valid held during busy with new pattern -> outputs unchanged until DONE; second command accepted only in IDLE.
REQ-037 SHALL cover: with KINASE_PUMP_REVERSE_EN, cmd_reverse=1, cycles=1 -> p[2:0] sequence 010,011,001,101,100,110.

Source files
------------

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: drives the c1..c13 control valves and s1..s4 sieve
// valves of a microfluidic kinase chip, waits for the valves to settle, then
// runs a six-phase peristaltic pump sequence on p1..p3 with the p4/p5
// isolation valves opened.
// Valve encoding: 1 = closed (pressurized), 0 = open. All outputs are registered.
// Optional feature: define KINASE_PUMP_REVERSE_EN to add the cmd_reverse input,
// which runs the pump phases in reverse order (5..0).
module kinase_valve_sequencer #(
  parameter int unsigned PHASE_TICKS  = 1000,
  parameter int unsigned SETTLE_TICKS = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [12:0] cmd_valves,
  input  logic [3:0]  cmd_sieve,
  input  logic [7:0]  cmd_pump_cycles,
`ifdef KINASE_PUMP_REVERSE_EN
  input  logic        cmd_reverse,
`endif
  input  logic        abort,
  output logic [12:0] c,
  output logic [3:0]  s,
  output logic [4:0]  p,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SETTLE, PUMP, DONE} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_TICKS - 1);
  localparam logic [15:0] PHASE_LAST  = 16'(PHASE_TICKS - 1);
  localparam logic [2:0]  STEP_LAST   = 3'd5;

  // p1..p3 pattern for a given pump step; reverse walks the table backwards.
  function automatic logic [2:0] pump_bits(input logic [2:0] step, input logic rev);
    logic [2:0] idx;
    idx = rev ? (STEP_LAST - step) : step;
    case (idx)
      3'd0:    pump_bits = 3'b110;
      3'd1:    pump_bits = 3'b100;
      3'd2:    pump_bits = 3'b101;
      3'd3:    pump_bits = 3'b001;
      3'd4:    pump_bits = 3'b011;
      3'd5:    pump_bits = 3'b010;
      default: pump_bits = 3'b111;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  cyc_q, cyc_d;
  logic        rev_q, rev_d;
  logic [12:0] c_q, c_d;
  logic [3:0]  s_q, s_d;
  logic [4:0]  p_q, p_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        cmd_rev_w;

`ifdef KINASE_PUMP_REVERSE_EN
  assign cmd_rev_w = cmd_reverse;
`else
  assign cmd_rev_w = 1'b0;
`endif

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    cyc_d   = cyc_q;
    rev_d   = rev_q;
    c_d     = c_q;
    s_d     = s_q;
    p_d     = p_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A same-cycle abort drops the offered command.
        if (cmd_valid && !abort) begin
          state_d = SETTLE;
          c_d     = cmd_valves;
          s_d     = cmd_sieve;
          cyc_d   = cmd_pump_cycles;
          rev_d   = cmd_rev_w;
          tick_d  = 16'd0;
          step_d  = 3'd0;
          p_d     = 5'h1F;
        end
      end

      SETTLE: begin
        if (tick_q == SETTLE_LAST) begin
          tick_d = 16'd0;
          step_d = 3'd0;
          if (cyc_q != 8'd0) begin
            state_d = PUMP;
            p_d     = {2'b00, pump_bits(3'd0, rev_q)};
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            p_d     = 5'h1F;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end

      PUMP: begin
        if (tick_q == PHASE_LAST) begin
          tick_d = 16'd0;
          if (step_q == STEP_LAST) begin
            step_d = 3'd0;
            if (cyc_q == 8'd1) begin
              state_d = DONE;
              cyc_d   = 8'd0;
              done_d  = 1'b1;
              p_d     = 5'h1F;
            end else begin
              cyc_d = cyc_q - 8'd1;
              p_d   = {2'b00, pump_bits(3'd0, rev_q)};
            end
          end else begin
            step_d = step_q + 3'd1;
            p_d    = {2'b00, pump_bits(step_q + 3'd1, rev_q)};
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end

      DONE: begin
        // c/s keep the last command pattern; only the pump closes.
        state_d = IDLE;
        p_d     = 5'h1F;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort closes every valve and discards the command from any busy state.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      tick_d  = 16'd0;
      step_d  = 3'd0;
      cyc_d   = 8'd0;
      rev_d   = 1'b0;
      c_d     = 13'h1FFF;
      s_d     = 4'hF;
      p_d     = 5'h1F;
      done_d  = 1'b0;
    end

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset closes all valves and clears the command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= 16'd0;
      step_q  <= 3'd0;
      cyc_q   <= 8'd0;
      rev_q   <= 1'b0;
      c_q     <= 13'h1FFF;
      s_q     <= 4'hF;
      p_q     <= 5'h1F;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      cyc_q   <= cyc_d;
      rev_q   <= rev_d;
      c_q     <= c_d;
      s_q     <= s_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign c         = c_q;
  assign s         = s_q;
  assign p         = p_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Testbench for kinase_valve_sequencer (PHASE_TICKS=2, SETTLE_TICKS=3).
// Define KINASE_PUMP_REVERSE_EN to also exercise the reverse pump option.
module tb_kinase_valve_sequencer;
  localparam int PT = 2;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_valves;
  logic [3:0]  cmd_sieve;
  logic [7:0]  cmd_pump_cycles;
`ifdef KINASE_PUMP_REVERSE_EN
  logic        cmd_reverse;
`endif
  logic        abort;
  logic [12:0] c;
  logic [3:0]  s;
  logic [4:0]  p;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  kinase_valve_sequencer #(.PHASE_TICKS(PT), .SETTLE_TICKS(ST)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_valves(cmd_valves),
    .cmd_sieve(cmd_sieve),
    .cmd_pump_cycles(cmd_pump_cycles),
`ifdef KINASE_PUMP_REVERSE_EN
    .cmd_reverse(cmd_reverse),
`endif
    .abort(abort),
    .c(c),
    .s(s),
    .p(p),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [12:0] valves;
    logic [3:0]  sieve;
    logic [7:0]  cycles;
    logic        rev;
    int          done_at;
    int          busy_len;
  } vec_t;

  typedef struct {
    logic [12:0] c;
    logic [3:0]  s;
    logic [4:0]  p;
    logic        busy;
    logic        done;
    logic        ready;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  logic [2:0]  pat [6];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_dut();
    return {7'd0, c, s, p, busy, done, cmd_ready};
  endfunction

  function automatic logic [31:0] pack_exp(input exp_t e);
    return {7'd0, e.c, e.s, e.p, e.busy, e.done, e.ready};
  endfunction

  // Expected per-cycle outputs from T+1 through the first idle cycle.
  task automatic push_trace(input logic [12:0] v, input logic [3:0] sv, input int n, input logic rev);
    exp_t e;
    e.c = v; e.s = sv; e.busy = 1'b1; e.done = 1'b0; e.ready = 1'b0; e.p = 5'h1F;
    for (int i = 0; i < ST; i++) sb_q.push_back(e);
    for (int k = 0; k < n; k++)
      for (int ph = 0; ph < 6; ph++)
        for (int t = 0; t < PT; t++) begin
          e.p = {2'b00, pat[rev ? 5 - ph : ph]};
          sb_q.push_back(e);
        end
    e.p = 5'h1F; e.done = 1'b1;
    sb_q.push_back(e);
    e.done = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag, output int busy_cnt, output int done_idx);
    exp_t e;
    int   i;
    i = 0; busy_cnt = 0; done_idx = -1;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      i++;
      e = sb_q.pop_front();
      check($sformatf("%s_cyc%0d", tag, i), pack_dut(), pack_exp(e));
      if (busy) busy_cnt++;
      if (done && done_idx < 0) done_idx = i;
    end
  endtask

  task automatic drive_cmd(input logic [12:0] v, input logic [3:0] sv, input logic [7:0] n, input logic rev);
    cmd_valid = 1'b1; cmd_valves = v; cmd_sieve = sv; cmd_pump_cycles = n;
`ifdef KINASE_PUMP_REVERSE_EN
    cmd_reverse = rev;
`else
    if (rev) $display("note: reverse requested without reverse build");
`endif
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int bc, di;
    logic [12:0] last_c;
    logic [3:0]  last_s;
    pat[0] = 3'b110; pat[1] = 3'b100; pat[2] = 3'b101;
    pat[3] = 3'b001; pat[4] = 3'b011; pat[5] = 3'b010;

    vecs.push_back('{13'h00A5, 4'h3, 8'd1,   1'b0, 16,   16});
    vecs.push_back('{13'h0000, 4'h0, 8'd0,   1'b0, 4,    4});
    vecs.push_back('{13'h1555, 4'hA, 8'd2,   1'b0, 28,   28});
`ifdef KINASE_PUMP_REVERSE_EN
    vecs.push_back('{13'h00A5, 4'h3, 8'd1,   1'b1, 16,   16});
`endif
    vecs.push_back('{13'h0001, 4'h8, 8'd255, 1'b0, 3064, 3064});

    rst = 1'b1; cmd_valid = 1'b0; cmd_valves = '0; cmd_sieve = '0;
    cmd_pump_cycles = '0; abort = 1'b0;
`ifdef KINASE_PUMP_REVERSE_EN
    cmd_reverse = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_outputs", {8'd0, c, s, p, busy, done}, {8'd0, 13'h1FFF, 4'hF, 5'h1F, 1'b0, 1'b0});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {30'd0, cmd_ready, busy}, {30'd0, 1'b1, 1'b0});
    @(posedge clk); #1;

    // Table of single commands, checked cycle by cycle via the scoreboard.
    for (int v = 0; v < vecs.size(); v++) begin
      drive_cmd(vecs[v].valves, vecs[v].sieve, vecs[v].cycles, vecs[v].rev);
      push_trace(vecs[v].valves, vecs[v].sieve, int'(vecs[v].cycles), vecs[v].rev);
      drain($sformatf("vec%0d", v), bc, di);
      check($sformatf("vec%0d_busy_len", v), bc, vecs[v].busy_len);
      check($sformatf("vec%0d_done_at", v), di, vecs[v].done_at);
      @(posedge clk); #1;
    end
    last_c = vecs[vecs.size() - 1].valves;
    last_s = vecs[vecs.size() - 1].sieve;

    // Abort in IDLE with a command offered: command dropped, outputs untouched.
    cmd_valid = 1'b1; abort = 1'b1; cmd_valves = 13'h0777; cmd_sieve = 4'h6; cmd_pump_cycles = 8'd1;
    @(posedge clk); #1 cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_drop", {1'd0, c, s, p, busy, done, cmd_ready, 8'd0},
          {1'd0, last_c, last_s, 5'h1F, 1'b0, 1'b0, 1'b1, 8'd0});
    @(posedge clk); #1;

    // Abort in phase 3 of pump cycle 2 of a 3-cycle command.
    drive_cmd(13'h00F0, 4'h5, 8'd3, 1'b0);
    repeat (21) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_before_p", {26'd0, p, busy}, {26'd0, 5'b00001, 1'b1});
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_outputs", {7'd0, c, s, p, busy, done, cmd_ready},
          {7'd0, 13'h1FFF, 4'hF, 5'h1F, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", i), {30'd0, busy, done}, 32'd0);
    end
    @(posedge clk); #1;

    // Command valid held while busy with a different pattern.
    cmd_valid = 1'b1; cmd_valves = 13'h00A5; cmd_sieve = 4'h3; cmd_pump_cycles = 8'd1;
    @(posedge clk); #1;
    cmd_valves = 13'h0155; cmd_sieve = 4'hC; cmd_pump_cycles = 8'd0;
    push_trace(13'h00A5, 4'h3, 1, 1'b0);
    drain("hold", bc, di);
    @(negedge clk);
    check("hold_second_accept", {10'd0, c, s, p}, {10'd0, 13'h0155, 4'hC, 5'h1F});
    check("hold_second_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_second_end", {17'd0, c, busy, done}, {17'd0, 13'h0155, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Asynchronous reset in the middle of pumping.
    drive_cmd(13'h00A5, 4'h3, 8'd1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_reset_p", {27'd0, p}, {27'd0, 5'b00100});
    #2 rst = 1'b1;
    #1;
    check("async_reset", {8'd0, c, s, p, busy, done}, {8'd0, 13'h1FFF, 4'hF, 5'h1F, 1'b0, 1'b0});
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {16'd0, c, busy, cmd_ready, done}, {16'd0, 13'h1FFF, 1'b0, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
